// File: rtl/trap_sequencer.sv
// Trap entry / URET sequencer for the RV32 multicycle core.
// Define TRAP_MEMFAULT_EN to enable the memory-check causes 4..7.
module trap_sequencer #(
  parameter logic [1:0] NUM_SEL_CSR   = 2'b00,
  parameter logic [1:0] NUM_SEL_UTVEC = 2'b01,
  parameter logic [1:0] NUM_SEL_UEPC  = 2'b10
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iCheckFetch,
  input  logic        iCheckDecode,
  input  logic        iCheckMem,
  input  logic        iIsLoad,
  input  logic        iIsStore,
  input  logic        iPCMisaligned,
  input  logic        iOutText,
  input  logic        iOutData,
  input  logic        iExceptionLoad,
  input  logic        iExceptionStore,
  input  logic        iIllegal,
  input  logic        iEcall,
  input  logic        iUret,
  output logic        oKill,
  output logic        oTrapActive,
  output logic [31:0] oUcause,
  output logic        oCCSRWrite,
  output logic [2:0]  oCOrigWriteDataCSR,
  output logic [1:0]  oSelectNumRegCSR,
  output logic        oCEscreveCRSOut,
  output logic        oCEscrevePC,
  output logic [1:0]  oCOrigPC,
  output logic [15:0] oTrapCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAUSE, S_EPC, S_VEC, S_JUMP, S_URET_RD, S_URET_JMP
  } state_t;

  state_t     state;
  logic       exc;
  logic [3:0] cause;
  logic       load_exc, load_data, store_exc, store_data;

`ifdef TRAP_MEMFAULT_EN
  assign load_exc   = iCheckMem & iIsLoad  & iExceptionLoad;
  assign load_data  = iCheckMem & iIsLoad  & iOutData;
  assign store_exc  = iCheckMem & iIsStore & iExceptionStore;
  assign store_data = iCheckMem & iIsStore & iOutData;
`else
  logic unused_mem;
  assign unused_mem = ^{iCheckMem, iIsLoad, iIsStore, iOutData, iExceptionLoad, iExceptionStore};
  assign load_exc   = 1'b0;
  assign load_data  = 1'b0;
  assign store_exc  = 1'b0;
  assign store_data = 1'b0;
`endif

  // Lowest cause code wins across all strobes; ecall (8) ranks below memory faults.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    exc   = 1'b1;
    cause = 4'd0;
    if      (iCheckFetch  & iPCMisaligned) cause = 4'd0;
    else if (iCheckFetch  & iOutText)      cause = 4'd1;
    else if (iCheckDecode & iIllegal)      cause = 4'd2;
    else if (load_exc)                     cause = 4'd4;
    else if (load_data)                    cause = 4'd5;
    else if (store_exc)                    cause = 4'd6;
    else if (store_data)                   cause = 4'd7;
    else if (iCheckDecode & iEcall)        cause = 4'd8;
    else                                   exc   = 1'b0;
  end

  assign oKill              = (state == S_IDLE) & exc;
  assign oCOrigWriteDataCSR = 3'b000;

  // Outputs are registered from the state being entered, so they line up with it.
  always_ff @(posedge iCLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (iRST) begin
      state            <= S_IDLE;
      oUcause          <= 32'd0;
      oTrapCount       <= 16'd0;
      oTrapActive      <= 1'b0;
      oCCSRWrite       <= 1'b0;
      oSelectNumRegCSR <= NUM_SEL_CSR;
      oCEscreveCRSOut  <= 1'b0;
      oCEscrevePC      <= 1'b0;
      oCOrigPC         <= 2'b00;
    end else begin
      oTrapActive      <= 1'b1;
      oCCSRWrite       <= 1'b0;
      oSelectNumRegCSR <= NUM_SEL_CSR;
      oCEscreveCRSOut  <= 1'b0;
      oCEscrevePC      <= 1'b0;
      oCOrigPC         <= 2'b00;
      unique case (state)
        S_IDLE: begin
          if (exc) begin
            state      <= S_CAUSE;
            oUcause    <= {28'd0, cause};
            oCCSRWrite <= 1'b1;
          end else if (iCheckDecode & iUret) begin
            state            <= S_URET_RD;
            oSelectNumRegCSR <= NUM_SEL_UEPC;
            oCEscreveCRSOut  <= 1'b1;
          end else begin
            oTrapActive <= 1'b0;
          end
        end
        S_CAUSE: begin
          state            <= S_EPC;
          oCCSRWrite       <= 1'b1;
          oSelectNumRegCSR <= NUM_SEL_UEPC;
        end
        S_EPC: begin
          state            <= S_VEC;
          oSelectNumRegCSR <= NUM_SEL_UTVEC;
          oCEscreveCRSOut  <= 1'b1;
        end
        S_VEC: begin
          state       <= S_JUMP;
          oCEscrevePC <= 1'b1;
          oCOrigPC    <= 2'b11;
          oTrapCount  <= oTrapCount + 16'd1;
        end
        S_URET_RD: begin
          state       <= S_URET_JMP;
          oCEscrevePC <= 1'b1;
          oCOrigPC    <= 2'b11;
        end
        default: begin
          state       <= S_IDLE;
          oTrapActive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomised scoreboard bench for trap_sequencer; the model tracks the fixed
// trap/URET timelines and the lowest-cause rule directly.
module tb_trap_sequencer;

  logic iCLK = 1'b0;
  logic iRST;
  logic iCheckFetch, iCheckDecode, iCheckMem, iIsLoad, iIsStore;
  logic iPCMisaligned, iOutText, iOutData, iExceptionLoad, iExceptionStore;
  logic iIllegal, iEcall, iUret;
  logic        oKill, oTrapActive, oCCSRWrite, oCEscreveCRSOut, oCEscrevePC;
  logic [31:0] oUcause;
  logic [2:0]  oCOrigWriteDataCSR;
  logic [1:0]  oSelectNumRegCSR, oCOrigPC;
  logic [15:0] oTrapCount;

  trap_sequencer dut (
    .iCLK(iCLK), .iRST(iRST),
    .iCheckFetch(iCheckFetch), .iCheckDecode(iCheckDecode), .iCheckMem(iCheckMem),
    .iIsLoad(iIsLoad), .iIsStore(iIsStore),
    .iPCMisaligned(iPCMisaligned), .iOutText(iOutText), .iOutData(iOutData),
    .iExceptionLoad(iExceptionLoad), .iExceptionStore(iExceptionStore),
    .iIllegal(iIllegal), .iEcall(iEcall), .iUret(iUret),
    .oKill(oKill), .oTrapActive(oTrapActive), .oUcause(oUcause),
    .oCCSRWrite(oCCSRWrite), .oCOrigWriteDataCSR(oCOrigWriteDataCSR),
    .oSelectNumRegCSR(oSelectNumRegCSR), .oCEscreveCRSOut(oCEscreveCRSOut),
    .oCEscrevePC(oCEscrevePC), .oCOrigPC(oCOrigPC), .oTrapCount(oTrapCount)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

`ifdef TRAP_MEMFAULT_EN
  localparam bit MEM_EN = 1'b1;
`else
  localparam bit MEM_EN = 1'b0;
`endif

  typedef struct packed {
    logic fetch, decode, mem, is_load, is_store;
    logic pcm, otext, odata, eload, estore, illegal, ecall, uret;
  } stim_t;

  typedef struct {
    bit          is_trap;
    int          cause;
    logic [15:0] count;
    int          cycle;
  } pcw_t;

  pcw_t        sb[$];
  logic [10:0] exp_ctrl [int];
  int          n_tests = 0;
  int          n_fail = 0;
  int          busy_until = -1;
  logic [15:0] model_count = 16'd0;
  logic [31:0] exp_ucause_cur = 32'd0;
  logic [31:0] exp_ucause_next = 32'd0;
  int          ucause_switch = -1;
  bit          mon_en = 1'b0;
  stim_t       st;
  logic [10:0] ctrl_vec;
  logic [10:0] mon_exp;
  pcw_t        mon_e;

  assign ctrl_vec = {oTrapActive, oCCSRWrite, oSelectNumRegCSR, oCEscreveCRSOut,
                     oCEscrevePC, oCOrigPC, oCOrigWriteDataCSR};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] mk(bit act, bit csrw, logic [1:0] sel, bit csrout,
                                     bit pcw, logic [1:0] orig);
    return {act, csrw, sel, csrout, pcw, orig, 3'b000};
  endfunction

  // Lowest-numbered cause among the enabled flags, or -1 if none.
  function automatic int ref_cause(stim_t s);
    bit en [9];
    for (int i = 0; i < 9; i++) en[i] = 1'b0;
    en[0] = s.fetch & s.pcm;
    en[1] = s.fetch & s.otext;
    en[2] = s.decode & s.illegal;
    en[8] = s.decode & s.ecall;
    if (MEM_EN) begin
      en[4] = s.mem & s.is_load  & s.eload;
      en[5] = s.mem & s.is_load  & s.odata;
      en[6] = s.mem & s.is_store & s.estore;
      en[7] = s.mem & s.is_store & s.odata;
    end
    for (int i = 0; i < 9; i++) if (en[i]) return i;
    return -1;
  endfunction

  task automatic drive(input stim_t s);
    iCheckFetch = s.fetch; iCheckDecode = s.decode; iCheckMem = s.mem;
    iIsLoad = s.is_load; iIsStore = s.is_store;
    iPCMisaligned = s.pcm; iOutText = s.otext; iOutData = s.odata;
    iExceptionLoad = s.eload; iExceptionStore = s.estore;
    iIllegal = s.illegal; iEcall = s.ecall; iUret = s.uret;
  endtask

  // One cycle of stimulus; expectations for the following cycles are queued here.
  task automatic step(input stim_t s);
    int c;
    bit idle;
    @(negedge iCLK);
    iRST = 1'b0;
    drive(s);
    #1;
    idle = (cyc > busy_until);
    c = ref_cause(s);
    check("kill", oKill, idle && c >= 0);
    if (idle && c >= 0) begin
      exp_ctrl[cyc + 1] = mk(1, 1, 2'b00, 0, 0, 2'b00);
      exp_ctrl[cyc + 2] = mk(1, 1, 2'b10, 0, 0, 2'b00);
      exp_ctrl[cyc + 3] = mk(1, 0, 2'b01, 1, 0, 2'b00);
      exp_ctrl[cyc + 4] = mk(1, 0, 2'b00, 0, 1, 2'b11);
      model_count = model_count + 16'd1;
      sb.push_back('{1'b1, c, model_count, cyc + 4});
      exp_ucause_next = c;
      ucause_switch = cyc + 1;
      busy_until = cyc + 4;
    end else if (idle && s.decode && s.uret) begin
      exp_ctrl[cyc + 1] = mk(1, 0, 2'b10, 1, 0, 2'b00);
      exp_ctrl[cyc + 2] = mk(1, 0, 2'b00, 0, 1, 2'b11);
      sb.push_back('{1'b0, 0, model_count, cyc + 2});
      busy_until = cyc + 2;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step('0);
  endtask

  // Reset in the middle of a sequence: the pending PC write is abandoned.
  task automatic reset_step();
    @(negedge iCLK);
    drive('0);
    iRST = 1'b1;
    #1;
    check("kill_in_rst", oKill, 1'b0);
    for (int k = cyc + 1; k <= cyc + 4; k++)
      if (exp_ctrl.exists(k)) exp_ctrl.delete(k);
    if (sb.size() > 0 && sb[sb.size() - 1].cycle > cyc) void'(sb.pop_back());
    model_count = 16'd0;
    exp_ucause_next = 32'd0;
    ucause_switch = cyc + 1;
    busy_until = cyc;
  endtask

  // Monitor: control vector and ucause every cycle, scoreboard pop on each PC write.
  always @(negedge iCLK) begin
    if (mon_en) begin
      if (cyc == ucause_switch) exp_ucause_cur = exp_ucause_next;
      mon_exp = exp_ctrl.exists(cyc) ? exp_ctrl[cyc] : 11'd0;
      check("ctrl", {21'd0, ctrl_vec}, {21'd0, mon_exp});
      check("ucause_hold", oUcause, exp_ucause_cur);
      if (oCEscrevePC === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_pc_write", oCEscrevePC, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("pcw_cycle", cyc, mon_e.cycle);
          check("pcw_count", oTrapCount, mon_e.count);
          if (mon_e.is_trap) check("pcw_ucause", oUcause, mon_e.cause);
        end
      end
    end
  end

  initial begin
    iRST = 1'b1;
    drive('0);
    repeat (2) @(posedge iCLK);
    #1 mon_en = 1'b1;
    @(negedge iCLK);
    #1;
    check("rst_ucause", oUcause, 32'd0);
    check("rst_count", oTrapCount, 16'd0);
    check("rst_active", oTrapActive, 1'b0);

    st = '0; st.fetch = 1; st.pcm = 1; step(st); idle_cycles(6);
    check("count_first", oTrapCount, model_count);

    st = '0; st.fetch = 1; st.pcm = 1; st.otext = 1; step(st); idle_cycles(6);
    st = '0; st.decode = 1; st.illegal = 1; st.ecall = 1; step(st); idle_cycles(6);

    st = '0; st.mem = 1; st.is_store = 1; st.estore = 1; step(st); idle_cycles(6);
    check("mem_store_count", oTrapCount, model_count);
    st = '0; st.mem = 1; st.is_load = 1; st.odata = 1; step(st); idle_cycles(6);

    st = '0; st.decode = 1; st.uret = 1; step(st); idle_cycles(4);
    check("uret_count", oTrapCount, model_count);
    st = '0; st.decode = 1; st.uret = 1; st.illegal = 1; step(st); idle_cycles(6);

    // Strobes while busy must be ignored.
    st = '0; st.fetch = 1; st.otext = 1; step(st);
    st = '0; st.decode = 1; st.ecall = 1; step(st);
    st = '0; st.fetch = 1; st.pcm = 1; step(st);
    st = '0; st.decode = 1; st.uret = 1; step(st);
    idle_cycles(4);

    // Reset while in VEC, then a fresh ecall trap.
    st = '0; st.decode = 1; st.ecall = 1; step(st);
    idle_cycles(2);
    reset_step();
    idle_cycles(1);
    check("rst_mid_count", oTrapCount, 16'd0);
    check("rst_mid_active", oTrapActive, 1'b0);
    st = '0; st.decode = 1; st.ecall = 1; step(st); idle_cycles(6);
    check("count_after_rst", oTrapCount, model_count);

    for (int i = 0; i < 300; i++) begin
      st = '0;
      st.fetch    = ($urandom_range(0, 4) == 0);
      st.decode   = ($urandom_range(0, 3) == 0);
      st.mem      = ($urandom_range(0, 3) == 0);
      st.is_load  = $urandom_range(0, 1);
      st.is_store = $urandom_range(0, 1);
      st.pcm      = ($urandom_range(0, 3) == 0);
      st.otext    = ($urandom_range(0, 3) == 0);
      st.odata    = ($urandom_range(0, 3) == 0);
      st.eload    = ($urandom_range(0, 3) == 0);
      st.estore   = ($urandom_range(0, 3) == 0);
      st.illegal  = ($urandom_range(0, 3) == 0);
      st.ecall    = ($urandom_range(0, 3) == 0);
      st.uret     = ($urandom_range(0, 2) == 0);
      step(st);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end

    idle_cycles(8);
    check("sb_empty", sb.size(), 0);
    check("final_count", oTrapCount, model_count);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
